// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-master / one-slave arbiter for an SRAM-like memory port.
//   Master 0 is the instruction-fetch path and master 1 is the load/store path.
//   Only one transaction is outstanding at a time. Master 1 has fixed priority.
//   A granted master keeps the grant until its data_ok.
// Ports:
//   clk, resetn             clock (rising edge) and asynchronous active-low reset
//   mN_req/we/addr/wdata    master N request channel
//   mN_addr_ok/data_ok      master N handshake outputs
//   mN_rdata                read data (s_rdata passthrough)
//   s_req/we/addr/wdata     slave request channel (muxed from winner/owner)
//   s_addr_ok/data_ok       slave handshakes
//   s_rdata                 slave read data
//   err                     sticky protocol-error flag, cleared only by reset
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_addr_ok,
  output logic              m0_data_ok,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_addr_ok,
  output logic              m1_data_ok,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_req,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   err_q, err_d;

  // Masters gathered into packed arrays so the muxing is indexed by master id.
  logic [1:0]             req, we;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;

  assign req   = {m1_req, m0_req};
  assign we    = {m1_we, m0_we};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  logic       sel;      // master whose request drives the slave this cycle
  logic       sreq;
  logic [1:0] aok, dok;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    err_d   = err_q;
    sel     = owner_q;
    sreq    = 1'b0;
    aok     = 2'b00;
    dok     = 2'b00;
    case (state_q)
      IDLE: begin
        sel = m1_req;  // data path wins ties
        if (m1_req || m0_req) begin
          sreq    = 1'b1;
          owner_d = sel;
          if (s_addr_ok) begin
            aok[sel] = 1'b1;
            state_d  = WAIT;
          end else begin
            state_d  = REQ;
          end
        end
        if (s_data_ok) err_d = 1'b1;
      end
      REQ: begin
        // Grant is locked to the owner; the other master is ignored.
        if (req[owner_q]) begin
          sreq = 1'b1;
          if (s_addr_ok) begin
            aok[owner_q] = 1'b1;
            state_d      = WAIT;
          end
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
        if (s_data_ok) err_d = 1'b1;
      end
      WAIT: begin
        if (s_data_ok) begin
          dok[owner_q] = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Combinational outputs are qualified by resetn so that every output is
  // forced low the moment reset asserts, not at the next clock edge.
  logic act;
  assign act = resetn && sreq;

  assign s_req   = act;
  assign s_we    = act && we[sel];
  assign s_addr  = act ? addr[sel]  : '0;
  assign s_wdata = act ? wdata[sel] : '0;

  assign m0_addr_ok = resetn && aok[0];
  assign m1_addr_ok = resetn && aok[1];
  assign m0_data_ok = resetn && dok[0];
  assign m1_data_ok = resetn && dok[1];
  assign m0_rdata   = resetn ? s_rdata : '0;
  assign m1_rdata   = resetn ? s_rdata : '0;

  assign err = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Stimulus pushes expected completions
// into a queue; a monitor pops one entry per data_ok seen on either master.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_req, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_addr_ok = 0, s_data_ok = 0;
  logic [DW-1:0] s_rdata = '0;
  logic          err;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          mst;
    logic [DW-1:0] data;
    logic          chk_data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: sample on the falling edge, away from input changes.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (m0_data_ok || m1_data_ok) begin
        chk("data_ok_onehot", {62'd0, m1_data_ok, m0_data_ok} == 64'd3, 64'd0);
        if (q.size() == 0) begin
          chk("unexpected_data_ok", {62'd0, m1_data_ok, m0_data_ok}, 64'd0);
        end else begin
          e = q.pop_front();
          chk("resp_master", {63'd0, m1_data_ok}, {63'd0, e.mst});
          if (e.chk_data)
            chk("resp_rdata", e.mst ? m1_rdata : m0_rdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs settle at posedge+1; outputs are checked just before the negedge.
  task automatic look();
    #3;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m1_req = 0; m1_we = 0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    tick(); tick();
    resetn = 1;
  endtask

  initial begin
    do_reset();

    // Reset state
    look();
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_s_req", {63'd0, s_req}, 64'd0);

    // Single inst read
    tick();
    m0_req = 1; m0_addr = 32'h1c000000; s_addr_ok = 1;
    look();
    chk("t1_m0_addr_ok", {63'd0, m0_addr_ok}, 64'd1);
    chk("t1_s_addr", {32'd0, s_addr}, 64'h1c000000);
    chk("t1_s_we", {63'd0, s_we}, 64'd0);
    chk("t1_m1_addr_ok", {63'd0, m1_addr_ok}, 64'd0);
    tick();
    m0_req = 0; s_addr_ok = 0;
    look();
    chk("t1_wait_s_req", {63'd0, s_req}, 64'd0);
    tick();
    s_data_ok = 1; s_rdata = 32'h02800421;
    q.push_back('{mst: 1'b0, data: 32'h02800421, chk_data: 1'b1});
    look();
    chk("t1_m0_data_ok", {63'd0, m0_data_ok}, 64'd1);
    chk("t1_m1_data_ok", {63'd0, m1_data_ok}, 64'd0);
    tick();
    s_data_ok = 0;

    // Contention: m1 write wins, m0 read served afterwards
    m0_req = 1; m0_we = 0; m0_addr = 32'h200;
    m1_req = 1; m1_we = 1; m1_addr = 32'h100; m1_wdata = 32'hdeadbeef;
    s_addr_ok = 1;
    look();
    chk("t2_s_addr", {32'd0, s_addr}, 64'h100);
    chk("t2_s_we", {63'd0, s_we}, 64'd1);
    chk("t2_s_wdata", {32'd0, s_wdata}, 64'hdeadbeef);
    chk("t2_m1_addr_ok", {63'd0, m1_addr_ok}, 64'd1);
    chk("t2_m0_addr_ok", {63'd0, m0_addr_ok}, 64'd0);
    tick();
    m1_req = 0; m1_we = 0;
    look();
    chk("t2_wait_m0_addr_ok", {63'd0, m0_addr_ok}, 64'd0);
    tick();
    s_data_ok = 1; s_rdata = 32'h0;
    q.push_back('{mst: 1'b1, data: 32'h0, chk_data: 1'b0});
    look();
    chk("t2_dok_m0_addr_ok", {63'd0, m0_addr_ok}, 64'd0);
    tick();
    s_data_ok = 0;
    look();
    chk("t2_m0_addr_ok_late", {63'd0, m0_addr_ok}, 64'd1);
    chk("t2_m0_s_addr", {32'd0, s_addr}, 64'h200);
    chk("t2_m0_s_we", {63'd0, s_we}, 64'd0);
    tick();
    m0_req = 0; s_addr_ok = 0;
    tick();
    s_data_ok = 1; s_rdata = 32'h11112222;
    q.push_back('{mst: 1'b0, data: 32'h11112222, chk_data: 1'b1});
    tick();
    s_data_ok = 0;

    // Grant lock: m0 waits in REQ while m1 arrives
    m0_req = 1; m0_addr = 32'h300; s_addr_ok = 0;
    look();
    chk("t3_c0_s_addr", {32'd0, s_addr}, 64'h300);
    chk("t3_c0_m0_addr_ok", {63'd0, m0_addr_ok}, 64'd0);
    for (int i = 1; i < 3; i++) begin
      tick();
      m1_req = 1; m1_addr = 32'h400;
      look();
      chk("t3_lock_s_addr", {32'd0, s_addr}, 64'h300);
      chk("t3_lock_m1_addr_ok", {63'd0, m1_addr_ok}, 64'd0);
      chk("t3_lock_m0_addr_ok", {63'd0, m0_addr_ok}, 64'd0);
    end
    tick();
    s_addr_ok = 1;
    look();
    chk("t3_m0_addr_ok", {63'd0, m0_addr_ok}, 64'd1);
    chk("t3_m1_addr_ok", {63'd0, m1_addr_ok}, 64'd0);
    chk("t3_s_addr", {32'd0, s_addr}, 64'h300);
    tick();
    m0_req = 0; s_addr_ok = 0;
    look();
    chk("t3_wait_m1_addr_ok", {63'd0, m1_addr_ok}, 64'd0);
    tick();
    s_data_ok = 1; s_rdata = 32'h33;
    q.push_back('{mst: 1'b0, data: 32'h33, chk_data: 1'b1});
    tick();
    s_data_ok = 0; s_addr_ok = 1;
    look();
    chk("t3_m1_served", {63'd0, m1_addr_ok}, 64'd1);
    tick();
    m1_req = 0; s_addr_ok = 0;
    tick();
    s_data_ok = 1; s_rdata = 32'h44;
    q.push_back('{mst: 1'b1, data: 32'h44, chk_data: 1'b1});
    tick();
    s_data_ok = 0;
    look();
    chk("t3_err_clear", {63'd0, err}, 64'd0);

    // Protocol error: s_data_ok while IDLE
    tick();
    s_data_ok = 1; s_rdata = 32'hbad;
    look();
    chk("t4_no_m0_dok", {63'd0, m0_data_ok}, 64'd0);
    chk("t4_no_m1_dok", {63'd0, m1_data_ok}, 64'd0);
    tick();
    s_data_ok = 0;
    look();
    chk("t4_err_set", {63'd0, err}, 64'd1);
    tick(); tick();
    look();
    chk("t4_err_sticky", {63'd0, err}, 64'd1);

    // Protocol error: m1 drops req in REQ
    do_reset();
    look();
    chk("t4b_err_reset", {63'd0, err}, 64'd0);
    tick();
    m1_req = 1; m1_addr = 32'h500; s_addr_ok = 0;
    tick();
    m1_req = 0;
    look();
    chk("t4b_drop_s_req", {63'd0, s_req}, 64'd0);
    chk("t4b_drop_m1_aok", {63'd0, m1_addr_ok}, 64'd0);
    tick();
    m0_req = 1; m0_addr = 32'h600; s_addr_ok = 1;
    look();
    chk("t4b_err", {63'd0, err}, 64'd1);
    chk("t4b_back_idle", {63'd0, m0_addr_ok}, 64'd1);
    tick();
    m0_req = 0; s_addr_ok = 0;
    tick();
    s_data_ok = 1; s_rdata = 32'h55;
    q.push_back('{mst: 1'b0, data: 32'h55, chk_data: 1'b1});
    tick();
    s_data_ok = 0;

    // Reset mid-transaction (in WAIT)
    do_reset();
    tick();
    m0_req = 1; m0_addr = 32'h700; s_addr_ok = 1;
    tick();
    m0_req = 0; s_addr_ok = 0;
    // Drive inputs that would make combinational outputs nonzero in IDLE.
    m1_req = 1; m1_we = 1; m1_addr = 32'h800; m1_wdata = 32'hcafe; s_addr_ok = 1;
    #2;
    resetn = 0;
    #1;
    chk("t5_s_req", {63'd0, s_req}, 64'd0);
    chk("t5_s_we", {63'd0, s_we}, 64'd0);
    chk("t5_s_addr", {32'd0, s_addr}, 64'd0);
    chk("t5_s_wdata", {32'd0, s_wdata}, 64'd0);
    chk("t5_addr_oks", {62'd0, m1_addr_ok, m0_addr_ok}, 64'd0);
    chk("t5_data_oks", {62'd0, m1_data_ok, m0_data_ok}, 64'd0);
    chk("t5_err", {63'd0, err}, 64'd0);
    tick();
    idle_inputs();
    resetn = 1;
    tick();
    m0_req = 1; m0_addr = 32'h900; s_addr_ok = 1;
    look();
    chk("t5_after_m0_aok", {63'd0, m0_addr_ok}, 64'd1);
    chk("t5_after_s_addr", {32'd0, s_addr}, 64'h900);
    tick();
    m0_req = 0; s_addr_ok = 0;
    tick();
    s_data_ok = 1; s_rdata = 32'h66;
    q.push_back('{mst: 1'b0, data: 32'h66, chk_data: 1'b1});
    tick();
    s_data_ok = 0;

    // Back-to-back: 8 m1 reads, one every 2 cycles
    m1_req = 1; m1_we = 0;
    for (int i = 0; i < 8; i++) begin
      m1_addr = 32'h1000 + 32'(4 * i); s_addr_ok = 1; s_data_ok = 0;
      look();
      chk("t6_m1_aok", {63'd0, m1_addr_ok}, 64'd1);
      chk("t6_s_addr", {32'd0, s_addr}, {32'd0, 32'h1000 + 32'(4 * i)});
      tick();
      s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'ha5000000 + 32'(i);
      q.push_back('{mst: 1'b1, data: 32'ha5000000 + 32'(i), chk_data: 1'b1});
      look();
      chk("t6_wait_s_req", {63'd0, s_req}, 64'd0);
      tick();
    end
    idle_inputs();
    tick(); tick();
    look();
    chk("t6_err", {63'd0, err}, 64'd0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    done = 1;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
